mips_multicycle_r: RTL and testbench
====================================

Name: mips_multicycle_r

Overview:
- Multi-cycle successor to the single-cycle R-type datapath.
- Parametrised register width, register-file depth and instruction-memory depth.
- Executes MIPS R-type instructions through a 4-state FSM (fetch/decode/execute/writeback) with real register writeback.
- Adds an instruction-memory program port, a HALT instruction, illegal-instruction flagging and a retired-instruction counter.
- Sits at the top of the processor subsystem, in place of the single-cycle top.

Parameters:
- DATA_W, 32: register/ALU width; legal range 8..64.
- NUM_REGS, 32: register-file entries; 16 or 32.
- IMEM_DEPTH, 64: instruction words; power of 2, at least 4.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- prog_we  in  1  instruction-memory write enable.
- prog_addr  in  log2(IMEM_DEPTH)  word address for the program write.
- prog_data  in  32  instruction word to write.
- out_G  out  DATA_W  last written-back ALU result.
- halted  out  1  core stopped on a HALT instruction.
- illegal  out  1  sticky flag: an illegal instruction was skipped.
- retired  out  CNT_W  count of instructions completed through WB.

Behaviour:
- Reset (async, rst=1): pc=0, state=FETCH, all registers 0, IR/A/B/ALUOut=0, out_G=0, halted=0, illegal=0, retired=0.
- Instruction memory is NOT cleared by reset.
- Program port: prog_we writes imem[prog_addr]<=prog_data on the clock edge, in any state including while rst=1.
  - The write is visible to a FETCH on the following cycle.
- pc is a byte address. Fetch index is pc[log2(IMEM_DEPTH)+1:2]. pc increments by 4 and wraps modulo 4*IMEM_DEPTH.
- Decode fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
- FSM, one cycle per state; a legal instruction takes exactly 4 cycles.
  - FETCH: IR<=imem[index]; pc<=pc+4; next DECODE.
  - DECODE: A<=rf[rs]; B<=rf[rt]; next EXEC.
    - An index >= NUM_REGS reads 0.
    - rf[0] always reads 0.
  - EXEC, classify the instruction:
    - op=6'h3F: next HALT.
    - op other than 0 or 3F, or unsupported funct: illegal<=1; next FETCH. No writeback, no retired increment.
    - Otherwise: ALUOut<=alu(A,B); next WB.
  - WB: rf[rd]<=ALUOut unless rd==0 or rd>=NUM_REGS (write dropped); out_G<=ALUOut; retired<=retired+1 (wraps); next FETCH.
    - out_G and retired update even when the register write is dropped.
  - HALT: halted=1; hold all state; leave only via rst.
- ALU functs (DATA_W bits, result truncated):
  - 20 add, 21 addu (wrapping; no overflow trap for either).
  - 22 sub, 23 subu.
  - 24 and, 25 or, 26 xor, 27 nor.
  - 2A slt (signed, result 1/0), 2B sltu.
  - 00 sll B by shamt, 02 srl B by shamt, 03 sra B by shamt.
  - Shift with shamt>=DATA_W: sll/srl give 0; sra gives sign fill.
  - 0x00000000 (sll r0,r0,0) is a legal NOP, retired normally.
- A WB to a register followed by a read of it in the next instruction's DECODE sees the new value; no hazard exists in the multi-cycle schedule.
- Reset asserted mid-instruction: state returns to reset values immediately and the in-flight instruction has no effect.
  - Releasing rst starts FETCH at pc=0 on the first rising edge.

Test Plan:
1. Load imem[0]=add r1,r0,r0; set r-values via a program of add/addi-free sequences: imem = {nor r1,r0,r0; add r2,r1,r1; srl r3,r1,shamt=28}. Required responses:
   - After 12 cycles: r1=FFFFFFFF, r2=FFFFFFFE, out_G=0000000F, retired=3.
   - Each instruction takes 4 cycles.
2. nor r0,r0,r0 -> out_G=FFFFFFFF, retired=1, and a following add r4,r0,r0 gives out_G=0, proving r0 stayed 0.
3. Signed/unsigned split with r1=FFFFFFFF, r2=0: slt r5,r1,r2 -> 1; sltu r6,r1,r2 -> 0; sra r7,r1,31 -> FFFFFFFF.
4. Illegal op 0x08 then unsupported funct 0x3E -> illegal=1, retired unchanged, pc advanced by 8, no register changed; a following HALT (op=3F) -> halted=1 three cycles after its FETCH, and pc/out_G frozen for 20 further cycles.
5. IMEM_DEPTH=4 with 4 NOPs -> after 16 cycles pc=0 again (wrap) and retired=4.
6. Assert rst during EXEC of add r1,…; program imem[0] while rst=1 -> r1 stays 0; after release the new imem[0] executes first.

Source files
------------

// File: rtl/mips_multicycle_r.sv
// Multi-cycle MIPS R-type core: fetch/decode/execute/writeback FSM with
// register writeback, a program-load port, HALT, illegal flagging and a
// retired-instruction counter.
module mips_multicycle_r #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  output logic [DATA_W-1:0]             out_G,
  output logic                          halted,
  output logic                          illegal,
  output logic [CNT_W-1:0]              retired
);

  localparam int unsigned IA_W = $clog2(IMEM_DEPTH);
  localparam int unsigned RA_W = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_nx;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] rf   [NUM_REGS];

  // The byte-address pc always has zero low bits, so only the word index
  // is stored; incrementing it by one equals pc+4 with wrap at 4*IMEM_DEPTH.
  logic [IA_W-1:0]   pc_idx;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_out;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt;

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];

  assign halted = (state == S_HALT);

  // Register index exists in the file (indices past the file read as 0).
  function automatic logic reg_ok(input logic [4:0] idx);
    return ({1'b0, idx} < 6'(NUM_REGS));
  endfunction

  logic [DATA_W-1:0] rs_val, rt_val;

  // Register-file read ports with r0 and out-of-range forced to zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0 && reg_ok(rs)) rs_val = rf[rs[RA_W-1:0]];
    if (rt != 5'd0 && reg_ok(rt)) rt_val = rf[rt[RA_W-1:0]];
  end

  logic [DATA_W-1:0] alu_res;
  logic              alu_ok;

  // ALU result selected by funct; alu_ok drops for unsupported functs.
  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (funct)
      6'h20, 6'h21: alu_res = a_q + b_q;
      6'h22, 6'h23: alu_res = a_q - b_q;
      6'h24:        alu_res = a_q & b_q;
      6'h25:        alu_res = a_q | b_q;
      6'h26:        alu_res = a_q ^ b_q;
      6'h27:        alu_res = ~(a_q | b_q);
      6'h2A:        alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      6'h2B:        alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
      6'h00:        alu_res = b_q << shamt;
      6'h02:        alu_res = b_q >> shamt;
      6'h03:        alu_res = DATA_W'($signed(b_q) >>> shamt);
      default:      alu_ok  = 1'b0;
    endcase
  end

  logic is_halt, is_illegal;

  // Next-state sequencing and instruction classification in EXEC.
  always_comb begin
    state_nx   = state;
    is_halt    = (op == 6'h3F);
    is_illegal = !is_halt && (op != 6'h00 || !alu_ok);
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        if (is_halt)         state_nx = S_HALT;
        else if (is_illegal) state_nx = S_FETCH;
        else                 state_nx = S_WB;
      end
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Program port; instruction memory is deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (prog_we) imem[prog_addr] <= prog_data;
  end

  // Datapath registers, register file and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_idx  <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      out_G   <= '0;
      illegal <= 1'b0;
      retired <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir     <= imem[pc_idx];
          pc_idx <= pc_idx + 1'b1;
        end
        S_DECODE: begin
          a_q <= rs_val;
          b_q <= rt_val;
        end
        S_EXEC: begin
          if (is_illegal)    illegal <= 1'b1;
          else if (!is_halt) alu_out <= alu_res;
        end
        S_WB: begin
          if (rd != 5'd0 && reg_ok(rd)) rf[rd[RA_W-1:0]] <= alu_out;
          out_G   <= alu_out;
          retired <= retired + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_r.sv
// Directed bench for mips_multicycle_r: a default-size core and a small
// core (16-bit data, 16 registers, 4-word program, 3-bit counter).
module tb_mips_multicycle_r;

  logic        clk = 1'b0;
  logic        rst, prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] out_G;
  logic        halted, illegal;
  logic [15:0] retired;

  logic        rst_s, pwe_s;
  logic [1:0]  paddr_s;
  logic [31:0] pdata_s;
  logic [15:0] outg_s;
  logic        halted_s, illegal_s;
  logic [2:0]  ret_s;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [31:0] ILL_OP = 32'h2001_0005;

  mips_multicycle_r u_dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .out_G(out_G), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  mips_multicycle_r #(
    .DATA_W(16), .NUM_REGS(16), .IMEM_DEPTH(4), .CNT_W(3)
  ) u_small (
    .clk(clk), .rst(rst_s), .prog_we(pwe_s), .prog_addr(paddr_s),
    .prog_data(pdata_s), .out_G(outg_s), .halted(halted_s),
    .illegal(illegal_s), .retired(ret_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rins(input logic [5:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic run(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic prog_main(input int unsigned addr, input logic [31:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 6'(addr); prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic prog_small(input int unsigned addr, input logic [31:0] data);
    @(negedge clk);
    pwe_s = 1'b1; paddr_s = 2'(addr); pdata_s = data;
    @(negedge clk);
    pwe_s = 1'b0;
  endtask

  logic [31:0] p1 [17];
  logic [31:0] e1 [16];

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    rst_s = 1'b1; pwe_s = 1'b0; paddr_s = '0; pdata_s = '0;

    // Reset state
    run(2);
    check_eq("rst out_G", out_G, 0);
    check_eq("rst halted", halted, 0);
    check_eq("rst illegal", illegal, 0);
    check_eq("rst retired", retired, 0);
    check_eq("rst small out_G", outg_s, 0);
    check_eq("rst small retired", ret_s, 0);

    // Test 1/3: ALU sweep, writeback-then-read, signed/unsigned split
    p1[0]  = rins(6'h27, 1, 0, 0, 0);   e1[0]  = 32'hFFFF_FFFF;
    p1[1]  = rins(6'h20, 2, 1, 1, 0);   e1[1]  = 32'hFFFF_FFFE;
    p1[2]  = rins(6'h02, 3, 0, 1, 28);  e1[2]  = 32'h0000_000F;
    p1[3]  = rins(6'h25, 8, 1, 0, 0);   e1[3]  = 32'hFFFF_FFFF;
    p1[4]  = rins(6'h25, 8, 2, 0, 0);   e1[4]  = 32'hFFFF_FFFE;
    p1[5]  = rins(6'h24, 2, 0, 0, 0);   e1[5]  = 32'h0000_0000;
    p1[6]  = rins(6'h2A, 5, 1, 2, 0);   e1[6]  = 32'h0000_0001;
    p1[7]  = rins(6'h2B, 6, 1, 2, 0);   e1[7]  = 32'h0000_0000;
    p1[8]  = rins(6'h03, 7, 0, 1, 31);  e1[8]  = 32'hFFFF_FFFF;
    p1[9]  = rins(6'h22, 9, 0, 1, 0);   e1[9]  = 32'h0000_0001;
    p1[10] = rins(6'h26, 10, 1, 3, 0);  e1[10] = 32'hFFFF_FFF0;
    p1[11] = rins(6'h00, 11, 0, 3, 4);  e1[11] = 32'h0000_00F0;
    p1[12] = rins(6'h23, 12, 3, 1, 0);  e1[12] = 32'h0000_0010;
    p1[13] = rins(6'h21, 13, 1, 1, 0);  e1[13] = 32'hFFFF_FFFE;
    p1[14] = rins(6'h24, 14, 1, 3, 0);  e1[14] = 32'h0000_000F;
    p1[15] = rins(6'h00, 15, 0, 1, 31); e1[15] = 32'h8000_0000;
    p1[16] = HALT_W;
    for (int i = 0; i < 17; i++) prog_main(i, p1[i]);
    rst = 1'b0;
    run(3);
    check_eq("t1 retired@3", retired, 0);
    run(1);
    check_eq("t1 out_G[0]", out_G, e1[0]);
    check_eq("t1 retired[0]", retired, 1);
    for (int i = 1; i < 16; i++) begin
      run(4);
      check_eq($sformatf("t1 out_G[%0d]", i), out_G, e1[i]);
      check_eq($sformatf("t1 retired[%0d]", i), retired, 16'(i + 1));
    end
    run(2);
    check_eq("t1 halted early", halted, 0);
    run(1);
    check_eq("t1 halted", halted, 1);

    // Test 2: r0 is never written
    rst = 1'b1;
    prog_main(0, rins(6'h27, 0, 0, 0, 0));
    prog_main(1, rins(6'h20, 4, 0, 0, 0));
    prog_main(2, HALT_W);
    rst = 1'b0;
    run(4);
    check_eq("t2 nor r0 out_G", out_G, 32'hFFFF_FFFF);
    check_eq("t2 nor r0 retired", retired, 1);
    run(4);
    check_eq("t2 add r4 out_G", out_G, 0);
    check_eq("t2 add r4 retired", retired, 2);

    // Test 4: illegal op, unsupported funct, then HALT freeze
    rst = 1'b1;
    prog_main(0, rins(6'h27, 1, 0, 0, 0));
    prog_main(1, ILL_OP);
    prog_main(2, rins(6'h3E, 1, 0, 0, 0));
    prog_main(3, rins(6'h25, 2, 1, 0, 0));
    prog_main(4, HALT_W);
    prog_main(5, rins(6'h24, 3, 0, 0, 0));
    rst = 1'b0;
    run(4);
    check_eq("t4 illegal before", illegal, 0);
    check_eq("t4 retired before", retired, 1);
    run(3);
    check_eq("t4 illegal op", illegal, 1);
    check_eq("t4 retired op", retired, 1);
    run(3);
    check_eq("t4 retired funct", retired, 1);
    run(4);
    check_eq("t4 r1 kept", out_G, 32'hFFFF_FFFF);
    check_eq("t4 retired after", retired, 2);
    run(2);
    check_eq("t4 halted early", halted, 0);
    run(1);
    check_eq("t4 halted", halted, 1);
    run(20);
    check_eq("t4 halted held", halted, 1);
    check_eq("t4 out_G frozen", out_G, 32'hFFFF_FFFF);
    check_eq("t4 retired frozen", retired, 2);
    check_eq("t4 illegal sticky", illegal, 1);

    // Test 6: reset during EXEC, reprogram under reset
    rst = 1'b1;
    prog_main(0, rins(6'h27, 2, 0, 0, 0));
    prog_main(1, rins(6'h27, 1, 0, 0, 0));
    prog_main(2, HALT_W);
    rst = 1'b0;
    run(4);
    check_eq("t6 first out_G", out_G, 32'hFFFF_FFFF);
    check_eq("t6 first retired", retired, 1);
    run(2);
    rst = 1'b1;
    #1;
    check_eq("t6 async out_G", out_G, 0);
    check_eq("t6 async retired", retired, 0);
    check_eq("t6 async illegal", illegal, 0);
    prog_main(0, rins(6'h25, 3, 1, 0, 0));
    prog_main(1, rins(6'h25, 3, 2, 0, 0));
    prog_main(2, HALT_W);
    rst = 1'b0;
    run(4);
    check_eq("t6 new imem0 out_G", out_G, 0);
    check_eq("t6 new imem0 retired", retired, 1);
    run(4);
    check_eq("t6 r2 cleared", out_G, 0);
    check_eq("t6 retired 2", retired, 2);
    run(3);
    check_eq("t6 halted", halted, 1);
    rst = 1'b1;

    // Test 5: small core, pc wrap and counter wrap
    prog_small(0, rins(6'h27, 1, 0, 0, 0));
    prog_small(1, 32'h0);
    prog_small(2, 32'h0);
    prog_small(3, 32'h0);
    rst_s = 1'b0;
    run(4);
    check_eq("t5 nor out_G", outg_s, 16'hFFFF);
    check_eq("t5 retired 1", ret_s, 1);
    run(12);
    check_eq("t5 nop out_G", outg_s, 0);
    check_eq("t5 retired 4", ret_s, 4);
    run(4);
    check_eq("t5 wrap out_G", outg_s, 16'hFFFF);
    check_eq("t5 wrap retired", ret_s, 5);
    run(12);
    check_eq("t5 counter wrap", ret_s, 0);
    check_eq("t5 small halted", halted_s, 0);
    check_eq("t5 small illegal", illegal_s, 0);

    // Small core: dropped writes to rd >= NUM_REGS, reads past file give 0
    rst_s = 1'b1;
    prog_small(0, rins(6'h27, 20, 0, 0, 0));
    prog_small(1, rins(6'h25, 2, 20, 0, 0));
    prog_small(2, rins(6'h27, 1, 0, 0, 0));
    prog_small(3, rins(6'h25, 5, 4, 0, 0));
    rst_s = 1'b0;
    run(4);
    check_eq("oob wb out_G", outg_s, 16'hFFFF);
    check_eq("oob wb retired", ret_s, 1);
    run(4);
    check_eq("oob read r20", outg_s, 0);
    run(4);
    check_eq("oob nor r1", outg_s, 16'hFFFF);
    check_eq("oob retired 3", ret_s, 3);
    run(4);
    check_eq("oob no alias r4", outg_s, 0);

    // Small core: shift amounts at or beyond DATA_W
    rst_s = 1'b1;
    prog_small(0, rins(6'h27, 1, 0, 0, 0));
    prog_small(1, rins(6'h00, 2, 0, 1, 20));
    prog_small(2, rins(6'h02, 3, 0, 1, 16));
    prog_small(3, rins(6'h03, 4, 0, 1, 17));
    rst_s = 1'b0;
    run(4);
    check_eq("shift src", outg_s, 16'hFFFF);
    run(4);
    check_eq("sll wide", outg_s, 0);
    run(4);
    check_eq("srl wide", outg_s, 0);
    run(4);
    check_eq("sra wide", outg_s, 16'hFFFF);
    check_eq("shift retired", ret_s, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
